// File: rtl/segment_transition_scheduler_pkg.sv
// Shared types and constants for the segment transition scheduler.
// Optional build macro used by this block: SEGMENT_SCHED_LATE_EN.
package segment_transition_scheduler_pkg;

  // Transition condition codes written by the controller register file.
  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX = 8'h00,
    TRANSITION_MODE_SYS_TIME = 8'h01,
    TRANSITION_MODE_GPIO     = 8'h02,
    TRANSITION_MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    SCHED_RUN     = 2'd0,
    SCHED_WAIT    = 2'd1,
    SCHED_STOPPED = 2'd2
  } seg_sched_state_t;

  localparam int unsigned SchedRepWidth = 16;
  // Repeat count meaning "loop forever".
  localparam logic [SchedRepWidth-1:0] RepInfinite = {SchedRepWidth{1'b1}};

  // Rising edge on the selected GPIO line, given the previous sample.
  function automatic logic gpio_rise(input logic [3:0] cur,
                                     input logic [3:0] prev,
                                     input logic [1:0] sel);
    return cur[sel] & ~prev[sel];
  endfunction

endpackage

// File: rtl/segment_transition_scheduler_if.sv
// Request bus from the controller register file into the scheduler.
interface segment_transition_scheduler_if #(
  parameter int RepWidth = 16
);
  logic                UPDATE;
  logic                REQ_RD_SEGMENT;
  logic [RepWidth-1:0] REP;
  logic [7:0]          TRANSITION_MODE;
  logic [63:0]         TRANSITION_VALUE;

  modport master (
    output UPDATE, REQ_RD_SEGMENT, REP, TRANSITION_MODE, TRANSITION_VALUE
  );

  modport slave (
    input UPDATE, REQ_RD_SEGMENT, REP, TRANSITION_MODE, TRANSITION_VALUE
  );
endinterface

// File: rtl/segment_transition_scheduler_idx_wrap_detector.sv
// Detects the running segment wrapping from its last index back to 0.
// WRAP is combinational on the current IDX so the scheduler reacts in the
// same cycle the counter shows index 0.
module idx_wrap_detector #(
  parameter int IdxWidth = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IdxWidth-1:0] IDX,
  input  logic [IdxWidth-1:0] CYCLE,
  output logic                WRAP
);

  logic [IdxWidth-1:0] idx_prev_q;

  // Previous-index register used to spot the CYCLE -> 0 step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_prev_q <= {IdxWidth{1'b0}};
    end else begin
      idx_prev_q <= IDX;
    end
  end

  assign WRAP = (idx_prev_q == CYCLE) && (IDX == {IdxWidth{1'b0}});

endmodule

// File: rtl/segment_transition_scheduler.sv
// Segment transition scheduler: latches a segment swap request, waits for
// its transition condition, swaps SEGMENT with a START pulse, and counts
// finite repeats to raise STOP.
// Optional build macro: SEGMENT_SCHED_LATE_EN adds the LATE output.
module segment_transition_scheduler
  import segment_transition_scheduler_pkg::*;
#(
  parameter int SysTimeWidth = 56,
  parameter int IdxWidth     = 15,
  parameter int RepWidth     = SchedRepWidth
) (
  input  logic                          CLK,
  input  logic                          RST,
  segment_transition_scheduler_if.slave req,
  input  logic [SysTimeWidth-1:0]       SYS_TIME,
  input  logic [3:0]                    GPIO_IN,
  input  logic [IdxWidth-1:0]           IDX,
  input  logic [IdxWidth-1:0]           CYCLE,
  output logic                          SEGMENT,
  output logic                          START,
  output logic                          STOP,
  output logic                          PENDING
`ifdef SEGMENT_SCHED_LATE_EN
  ,output logic                         LATE
`endif
);

  localparam logic [RepWidth-1:0] RepInf = {RepWidth{1'b1}};
  localparam logic [RepWidth-1:0] RepOne = {{(RepWidth-1){1'b0}}, 1'b1};

  seg_sched_state_t    state_q, state_d;
  logic                seg_q, seg_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                pending_q, pending_d;
  logic                req_seg_q, req_seg_d;
  logic [RepWidth-1:0] rep_q, rep_d;
  logic [RepWidth-1:0] cnt_q, cnt_d;
  logic [7:0]          mode_q, mode_d;
  logic [63:0]         value_q, value_d;
  logic                from_stop_q, from_stop_d;  // request issued while stopped
  logic                ext_q, ext_d;              // EXT auto-toggle active
  logic [3:0]          gpio_prev_q;
  logic                wrap_s;
  logic                cond_s;
  logic                unused_value_bits_s;

  assign unused_value_bits_s = ^value_q[63:SysTimeWidth];

  idx_wrap_detector #(
    .IdxWidth(IdxWidth)
  ) u_wrap (
    .CLK  (CLK),
    .RST  (RST),
    .IDX  (IDX),
    .CYCLE(CYCLE),
    .WRAP (wrap_s)
  );

  // Previous GPIO sample for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_prev_q <= 4'b0000;
    end else begin
      gpio_prev_q <= GPIO_IN;
    end
  end

  // Transition condition for the pending request; unknown codes act as SYNC_IDX.
  // A stopped datapath never wraps, so a sync request issued from STOPPED fires at once.
  always_comb begin
    cond_s = 1'b0;
    case (mode_q)
      TRANSITION_MODE_SYS_TIME: cond_s = (SYS_TIME >= value_q[SysTimeWidth-1:0]);
      TRANSITION_MODE_GPIO:     cond_s = gpio_rise(GPIO_IN, gpio_prev_q, value_q[1:0]);
      default:                  cond_s = wrap_s | from_stop_q;
    endcase
  end

  // Next-state and output logic; a new UPDATE always takes priority.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    start_d     = 1'b0;
    stop_d      = stop_q;
    pending_d   = pending_q;
    req_seg_d   = req_seg_q;
    rep_d       = rep_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    value_d     = value_q;
    from_stop_d = from_stop_q;
    ext_d       = ext_q;
    if (req.UPDATE) begin
      req_seg_d   = req.REQ_RD_SEGMENT;
      rep_d       = req.REP;
      mode_d      = req.TRANSITION_MODE;
      value_d     = req.TRANSITION_VALUE;
      from_stop_d = (state_q == SCHED_STOPPED) || ((state_q == SCHED_WAIT) && from_stop_q);
      pending_d   = 1'b1;
      state_d     = SCHED_WAIT;
    end else begin
      case (state_q)
        SCHED_WAIT: begin
          if (cond_s) begin
            seg_d       = req_seg_q;
            start_d     = 1'b1;
            stop_d      = 1'b0;
            pending_d   = 1'b0;
            cnt_d       = {RepWidth{1'b0}};
            from_stop_d = 1'b0;
            ext_d       = (mode_q == TRANSITION_MODE_EXT);
            state_d     = SCHED_RUN;
          end else begin
            state_d = SCHED_WAIT;
          end
        end
        SCHED_RUN: begin
          if (wrap_s) begin
            if (ext_q) begin
              seg_d   = ~seg_q;
              start_d = 1'b1;
            end else if (rep_q == RepInf) begin
              cnt_d = cnt_q;
            end else if (cnt_q == rep_q) begin
              stop_d  = 1'b1;
              state_d = SCHED_STOPPED;
            end else begin
              cnt_d = cnt_q + RepOne;
            end
          end else begin
            state_d = SCHED_RUN;
          end
        end
        SCHED_STOPPED: begin
          state_d = SCHED_STOPPED;
        end
        default: begin
          state_d   = SCHED_RUN;
          pending_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SCHED_RUN;
      seg_q       <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      pending_q   <= 1'b0;
      req_seg_q   <= 1'b0;
      rep_q       <= RepInf;
      cnt_q       <= {RepWidth{1'b0}};
      mode_q      <= 8'h00;
      value_q     <= 64'h0;
      from_stop_q <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      pending_q   <= pending_d;
      req_seg_q   <= req_seg_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      from_stop_q <= from_stop_d;
      ext_q       <= ext_d;
    end
  end

  assign SEGMENT = seg_q;
  assign START   = start_q;
  assign STOP    = stop_q;
  assign PENDING = pending_q;

`ifdef SEGMENT_SCHED_LATE_EN
  logic late_q, late_d;

  // LATE marks a SYS_TIME request already past its target when latched.
  always_comb begin
    late_d = late_q;
    if (req.UPDATE) begin
      late_d = (req.TRANSITION_MODE == TRANSITION_MODE_SYS_TIME) &&
               (SYS_TIME >= req.TRANSITION_VALUE[SysTimeWidth-1:0]);
    end else begin
      late_d = late_q;
    end
  end

  // LATE flag register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      late_q <= 1'b0;
    end else begin
      late_q <= late_d;
    end
  end

  assign LATE = late_q;
`endif

endmodule

// File: tb/tb_segment_transition_scheduler.sv
// Directed self-checking bench for segment_transition_scheduler.
module tb_segment_transition_scheduler;
  import segment_transition_scheduler_pkg::*;

  logic        CLK;
  logic        RST;
  logic [55:0] SYS_TIME;
  logic [3:0]  GPIO_IN;
  logic [14:0] IDX;
  logic [14:0] CYCLE;
  logic        seg, start, stop, pending;
`ifdef SEGMENT_SCHED_LATE_EN
  logic        late;
`endif

  int n_cmp = 0;
  int n_err = 0;

  segment_transition_scheduler_if #(.RepWidth(16)) req_if ();

  segment_transition_scheduler dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req_if),
    .SYS_TIME(SYS_TIME),
    .GPIO_IN (GPIO_IN),
    .IDX     (IDX),
    .CYCLE   (CYCLE),
    .SEGMENT (seg),
    .START   (start),
    .STOP    (stop),
    .PENDING (pending)
`ifdef SEGMENT_SCHED_LATE_EN
    ,.LATE   (late)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic s, input logic [15:0] rep,
                         input logic [7:0] mode, input logic [63:0] val);
    req_if.UPDATE           = 1'b1;
    req_if.REQ_RD_SEGMENT   = s;
    req_if.REP              = rep;
    req_if.TRANSITION_MODE  = mode;
    req_if.TRANSITION_VALUE = val;
  endtask

  initial begin
    RST = 1'b1; SYS_TIME = 56'd0; GPIO_IN = 4'b0000; IDX = 15'd0; CYCLE = 15'd3;
    req_if.UPDATE = 1'b0; req_if.REQ_RD_SEGMENT = 1'b0; req_if.REP = 16'hFFFF;
    req_if.TRANSITION_MODE = 8'h00; req_if.TRANSITION_VALUE = 64'd0;
    tick(); tick();
    chk("rst_segment", {63'd0, seg}, 64'd0);
    chk("rst_start",   {63'd0, start}, 64'd0);
    chk("rst_stop",    {63'd0, stop}, 64'd0);
    chk("rst_pending", {63'd0, pending}, 64'd0);
`ifdef SEGMENT_SCHED_LATE_EN
    chk("rst_late",    {63'd0, late}, 64'd0);
`endif
    RST = 1'b0;

    // SYNC_IDX: request at IDX=1, swap after IDX 3->0
    IDX = 15'd1; tick();
    set_req(1'b1, 16'hFFFF, TRANSITION_MODE_SYNC_IDX, 64'd0); IDX = 15'd2; tick();
    chk("sync_pending_set", {63'd0, pending}, 64'd1);
    chk("sync_no_early_seg", {63'd0, seg}, 64'd0);
    req_if.UPDATE = 1'b0; IDX = 15'd3; tick();
    chk("sync_wait_start", {63'd0, start}, 64'd0);
    chk("sync_wait_pending", {63'd0, pending}, 64'd1);
    IDX = 15'd0; tick();
    chk("sync_start", {63'd0, start}, 64'd1);
    chk("sync_segment", {63'd0, seg}, 64'd1);
    chk("sync_pending_clr", {63'd0, pending}, 64'd0);
    IDX = 15'd1; tick();
    chk("sync_start_pulse", {63'd0, start}, 64'd0);

    // SYS_TIME: target 1000, ramp from 990 (IDX held, no wraps)
    SYS_TIME = 56'd990;
    set_req(1'b0, 16'hFFFF, TRANSITION_MODE_SYS_TIME, 64'd1000); tick();
    chk("time_pending", {63'd0, pending}, 64'd1);
    req_if.UPDATE = 1'b0;
    for (int t = 991; t <= 999; t++) begin
      SYS_TIME = 56'(t); tick();
      chk("time_before_target", {63'd0, start}, 64'd0);
    end
    SYS_TIME = 56'd1000; tick();
    chk("time_start", {63'd0, start}, 64'd1);
    chk("time_segment", {63'd0, seg}, 64'd0);
    SYS_TIME = 56'd1001; tick();
    chk("time_start_pulse", {63'd0, start}, 64'd0);

    // Past-due SYS_TIME request: swaps on the first WAIT cycle
    SYS_TIME = 56'd1005;
    set_req(1'b1, 16'hFFFF, TRANSITION_MODE_SYS_TIME, 64'd1000); tick();
    chk("late_req_pending", {63'd0, pending}, 64'd1);
    chk("late_req_no_start", {63'd0, start}, 64'd0);
`ifdef SEGMENT_SCHED_LATE_EN
    chk("late_flag_set", {63'd0, late}, 64'd1);
`endif
    req_if.UPDATE = 1'b0; tick();
    chk("late_req_start", {63'd0, start}, 64'd1);
    chk("late_req_segment", {63'd0, seg}, 64'd1);

    // GPIO: select line 2, pulse on line 1 is ignored
    set_req(1'b0, 16'hFFFF, TRANSITION_MODE_GPIO, 64'd2); tick();
    chk("gpio_pending", {63'd0, pending}, 64'd1);
`ifdef SEGMENT_SCHED_LATE_EN
    chk("late_flag_clr", {63'd0, late}, 64'd0);
`endif
    req_if.UPDATE = 1'b0; GPIO_IN = 4'b0010; tick();
    chk("gpio_wrong_line", {63'd0, start}, 64'd0);
    GPIO_IN = 4'b0000; tick();
    chk("gpio_wrong_line_seg", {63'd0, seg}, 64'd1);
    GPIO_IN = 4'b0100; tick();
    chk("gpio_start", {63'd0, start}, 64'd1);
    chk("gpio_segment", {63'd0, seg}, 64'd0);
    tick();
    chk("gpio_level_no_retrigger", {63'd0, start}, 64'd0);

    // Finite REP=1: two wraps after START, then STOP
    set_req(1'b1, 16'd1, TRANSITION_MODE_SYNC_IDX, 64'd0); IDX = 15'd2; tick();
    req_if.UPDATE = 1'b0; IDX = 15'd3; tick();
    IDX = 15'd0; tick();
    chk("rep_swap_start", {63'd0, start}, 64'd1);
    chk("rep_swap_segment", {63'd0, seg}, 64'd1);
    IDX = 15'd1; tick(); IDX = 15'd2; tick(); IDX = 15'd3; tick(); IDX = 15'd0; tick();
    chk("rep_first_wrap_no_stop", {63'd0, stop}, 64'd0);
    IDX = 15'd1; tick(); IDX = 15'd2; tick(); IDX = 15'd3; tick(); IDX = 15'd0; tick();
    chk("rep_stop", {63'd0, stop}, 64'd1);
    chk("rep_stop_no_start", {63'd0, start}, 64'd0);
    IDX = 15'd3; tick();
    chk("rep_stop_held", {63'd0, stop}, 64'd1);
    set_req(1'b0, 16'hFFFF, TRANSITION_MODE_SYNC_IDX, 64'd0); tick();
    chk("stopped_update_pending", {63'd0, pending}, 64'd1);
    req_if.UPDATE = 1'b0; tick();
    chk("stopped_sync_start", {63'd0, start}, 64'd1);
    chk("stopped_sync_segment", {63'd0, seg}, 64'd0);
    chk("stopped_sync_stop_clr", {63'd0, stop}, 64'd0);

    // Overwrite: GPIO request replaced by SYNC_IDX before its edge
    GPIO_IN = 4'b0000;
    set_req(1'b1, 16'hFFFF, TRANSITION_MODE_GPIO, 64'd2); tick();
    set_req(1'b0, 16'hFFFF, TRANSITION_MODE_SYNC_IDX, 64'd0); tick();
    req_if.UPDATE = 1'b0; GPIO_IN = 4'b0100; tick();
    chk("ovw_gpio_ignored", {63'd0, start}, 64'd0);
    chk("ovw_still_pending", {63'd0, pending}, 64'd1);
    chk("ovw_segment_held", {63'd0, seg}, 64'd0);
    IDX = 15'd0; tick();
    chk("ovw_wrap_start", {63'd0, start}, 64'd1);
    chk("ovw_wrap_segment", {63'd0, seg}, 64'd0);

    // EXT: first swap to 1, then each wrap toggles SEGMENT
    set_req(1'b1, 16'd0, TRANSITION_MODE_EXT, 64'd0); IDX = 15'd1; tick();
    req_if.UPDATE = 1'b0; IDX = 15'd2; tick(); IDX = 15'd3; tick(); IDX = 15'd0; tick();
    chk("ext_first_start", {63'd0, start}, 64'd1);
    chk("ext_first_segment", {63'd0, seg}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      IDX = 15'd1; tick();
      chk("ext_mid_loop_start", {63'd0, start}, 64'd0);
      IDX = 15'd2; tick(); IDX = 15'd3; tick(); IDX = 15'd0; tick();
      chk("ext_toggle_start", {63'd0, start}, 64'd1);
      chk("ext_toggle_segment", {63'd0, seg}, {63'd0, k[0]});
      chk("ext_no_stop", {63'd0, stop}, 64'd0);
    end

    // RST while a request is pending
    set_req(1'b0, 16'hFFFF, TRANSITION_MODE_SYNC_IDX, 64'd0); IDX = 15'd1; tick();
    chk("rstwait_pending", {63'd0, pending}, 64'd1);
    req_if.UPDATE = 1'b0; RST = 1'b1; tick();
    chk("rstwait_segment", {63'd0, seg}, 64'd0);
    chk("rstwait_pending_clr", {63'd0, pending}, 64'd0);
    RST = 1'b0; IDX = 15'd2; tick(); IDX = 15'd3; tick(); IDX = 15'd0; tick();
    chk("rstwait_dropped_no_start", {63'd0, start}, 64'd0);
    chk("rstwait_no_toggle", {63'd0, seg}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
